// File: rtl/kros_pkg.sv
// Shared constants and the recorder state encoding for the KROS LED pattern blocks
// (throttle, sequencer, pattern recorder).
package kros_pkg;

    localparam int KROS_DATA_W = 10;
    localparam int KROS_ADDR_W = 10;
    localparam int KROS_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EDIT  = 2'd1,
        WRITE = 2'd2,
        CLEAR = 2'd3
    } rec_state_t;

endpackage

// File: rtl/pattern_recorder_pb_edge.sv
// pb_edge: registers a debounced pushbutton level and emits a 1-cycle pulse
// on the cycle after the register captures a rising level.
module pb_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level;
    logic r_level_d;

    // NOTE: clocked state uses <= so both stages sample the pre-edge values; blocking
    // assignments here would collapse the two flops into one and the edge would never be seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level   <= i_level;
            r_level_d <= r_level;
        end
    end

    assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/pattern_recorder.sv
// pattern_recorder: composes LED patterns from pushbutton events and writes them to the RAM write port.
// Build option: define REC_OVERWRITE_EN to let stores wrap over the oldest word when full.
module pattern_recorder
    import kros_pkg::*;
#(
    parameter int DATA_W = KROS_DATA_W,
    parameter int ADDR_W = KROS_ADDR_W,
    parameter int DEPTH  = KROS_DEPTH
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic              rec_en,
    input  logic              pb_toggle,
    input  logic              pb_next,
    input  logic              pb_store,
    input  logic              pb_clear,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic [DATA_W-1:0] edit_pattern,
    output logic [3:0]        cursor,
    output logic [ADDR_W:0]   seq_len,
    output logic              busy,
    output logic              full,
    output logic              overflow
);

    localparam int              LEN_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(DEPTH);
    localparam logic [3:0]        LAST_BIT  = 4'(DATA_W - 1);

    logic w_ev_toggle;
    logic w_ev_next;
    logic w_ev_store;
    logic w_ev_clear;
    logic w_store_ok;

    logic [LEN_W-1:0]  w_wptr_inc;
    logic [LEN_W-1:0]  w_len_next;
    logic [ADDR_W-1:0] w_wptr_next;

    rec_state_t        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;
    logic [DATA_W-1:0] r_edit;
    logic [3:0]        r_cursor;
    logic [LEN_W-1:0]  r_seq_len;
    logic              r_busy;
    logic              r_full;
    logic              r_overflow;

    pb_edge u_pb_toggle (.clk(CLK_50), .rst(reset), .i_level(pb_toggle), .o_rise(w_ev_toggle));
    pb_edge u_pb_next   (.clk(CLK_50), .rst(reset), .i_level(pb_next),   .o_rise(w_ev_next));
    pb_edge u_pb_store  (.clk(CLK_50), .rst(reset), .i_level(pb_store),  .o_rise(w_ev_store));
    pb_edge u_pb_clear  (.clk(CLK_50), .rst(reset), .i_level(pb_clear),  .o_rise(w_ev_clear));

`ifdef REC_OVERWRITE_EN
    assign w_store_ok = 1'b1;
`else
    assign w_store_ok = ~r_full;
`endif

    assign w_wptr_inc  = {1'b0, r_wptr} + 1'b1;
    assign w_len_next  = (w_wptr_inc > r_seq_len) ? w_wptr_inc : r_seq_len;
    assign w_wptr_next = (r_wptr == LAST_ADDR) ? '0 : r_wptr + 1'b1;

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_wren <= 1'b0;
            r_edit     <= '0;
            r_cursor   <= '0;
            r_seq_len  <= '0;
            r_busy     <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rec_en) r_state <= EDIT;
                end
                EDIT: begin
                    // Leaving record mode wins over any event in the same cycle.
                    if (!rec_en) begin
                        r_state <= IDLE;
                    end else if (w_ev_clear) begin
                        r_state    <= CLEAR;
                        r_ram_wren <= 1'b1;
                        r_ram_addr <= '0;
                        r_ram_data <= '0;
                        r_busy     <= 1'b1;
                    end else if (w_ev_store) begin
                        if (w_store_ok) begin
                            r_state    <= WRITE;
                            r_ram_wren <= 1'b1;
                            r_ram_addr <= r_wptr;
                            r_ram_data <= r_edit;
                            r_busy     <= 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else if (w_ev_toggle) begin
                        r_edit[r_cursor] <= ~r_edit[r_cursor];
                    end else if (w_ev_next) begin
                        r_cursor <= (r_cursor == LAST_BIT) ? 4'd0 : r_cursor + 4'd1;
                    end
                end
                WRITE: begin
                    r_state    <= EDIT;
                    r_ram_wren <= 1'b0;
                    r_busy     <= 1'b0;
                    r_wptr     <= w_wptr_next;
                    r_seq_len  <= w_len_next;
                    r_full     <= (w_len_next == LEN_FULL);
                end
                CLEAR: begin
                    if (r_ram_addr == LAST_ADDR) begin
                        r_state    <= EDIT;
                        r_ram_wren <= 1'b0;
                        r_busy     <= 1'b0;
                        r_wptr     <= '0;
                        r_seq_len  <= '0;
                        r_full     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_edit     <= '0;
                    end else begin
                        r_ram_addr <= r_ram_addr + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_wraddress = r_ram_addr;
    assign ram_data      = r_ram_data;
    assign ram_wren      = r_ram_wren;
    assign edit_pattern  = r_edit;
    assign cursor        = r_cursor;
    assign seq_len       = r_seq_len;
    assign busy          = r_busy;
    assign full          = r_full;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_pattern_recorder.sv
// Directed testbench for pattern_recorder built with DEPTH=4; expectations follow REC_OVERWRITE_EN.
module tb_pattern_recorder;
    import kros_pkg::*;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              rec_en;
    logic              pb_toggle;
    logic              pb_next;
    logic              pb_store;
    logic              pb_clear;
    logic [ADDR_W-1:0] ram_wraddress;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] edit_pattern;
    logic [3:0]        cursor;
    logic [ADDR_W:0]   seq_len;
    logic              busy;
    logic              full;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_recorder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK_50       (clk),
        .reset        (reset),
        .rec_en       (rec_en),
        .pb_toggle    (pb_toggle),
        .pb_next      (pb_next),
        .pb_store     (pb_store),
        .pb_clear     (pb_clear),
        .ram_wraddress(ram_wraddress),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .edit_pattern (edit_pattern),
        .cursor       (cursor),
        .seq_len      (seq_len),
        .busy         (busy),
        .full         (full),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Raise the selected buttons for one cycle; the resulting action lands on the next posedge.
    task automatic press(input logic t, input logic n, input logic s, input logic c);
        @(negedge clk);
        pb_toggle = t; pb_next = n; pb_store = s; pb_clear = c;
        @(negedge clk);
        pb_toggle = 1'b0; pb_next = 1'b0; pb_store = 1'b0; pb_clear = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; rec_en = 1'b0;
        pb_toggle = 1'b0; pb_next = 1'b0; pb_store = 1'b0; pb_clear = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ram_wraddress, ram_data, ram_wren, edit_pattern, cursor, seq_len, busy, full, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: wren=%b addr=%0h data=%0h edit=%0h cur=%0d len=%0d busy=%b full=%b ovf=%b, all must be 0",
                     ram_wren, ram_wraddress, ram_data, edit_pattern, cursor, seq_len, busy, full, overflow);
        end
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.r_state);
        end
        reset = 1'b0; rec_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut.r_state !== EDIT) begin
            n_fail++; $display("FAIL enter_edit: got %0d want EDIT", dut.r_state);
        end
        n_checks++;
        if ({ram_wren, edit_pattern, cursor, seq_len} !== '0) begin
            n_fail++; $display("FAIL edit_outputs: wren=%b edit=%0h cur=%0d len=%0d, all must be 0",
                               ram_wren, edit_pattern, cursor, seq_len);
        end
    endtask

    task automatic test_edit_store;
        repeat (3) press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (cursor !== 4'd3) begin
            n_fail++; $display("FAIL cursor_after_next: got %0d want 3", cursor);
        end
        n_checks++;
        if (edit_pattern !== 10'h008) begin
            n_fail++; $display("FAIL toggle_bit3: got %0h want 008", edit_pattern);
        end
        press(0, 0, 1, 0);
        @(negedge clk);
        n_checks++;
        if ({ram_wren, busy, ram_wraddress, ram_data} !== {1'b1, 1'b1, 10'd0, 10'h008}) begin
            n_fail++; $display("FAIL store_write: wren=%b busy=%b addr=%0h data=%0h want 1 1 0 008",
                               ram_wren, busy, ram_wraddress, ram_data);
        end
        @(negedge clk);
        n_checks++;
        if ({ram_wren, busy, seq_len, full} !== {1'b0, 1'b0, 11'd1, 1'b0}) begin
            n_fail++; $display("FAIL store_done: wren=%b busy=%b len=%0d full=%b want 0 0 1 0",
                               ram_wren, busy, seq_len, full);
        end
    endtask

    task automatic test_same_cycle;
        press(1, 0, 1, 0);
        @(negedge clk);
        n_checks++;
        if ({ram_wren, ram_wraddress, ram_data} !== {1'b1, 10'd1, 10'h008}) begin
            n_fail++; $display("FAIL same_cycle_write: wren=%b addr=%0h data=%0h want 1 1 008",
                               ram_wren, ram_wraddress, ram_data);
        end
        @(negedge clk);
        n_checks++;
        if ({edit_pattern, seq_len} !== {10'h008, 11'd2}) begin
            n_fail++; $display("FAIL same_cycle_after: edit=%0h len=%0d want 008 2", edit_pattern, seq_len);
        end
    endtask

    task automatic test_clear;
        press(0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ram_wren, busy, ram_wraddress, ram_data} !== {1'b1, 1'b1, ADDR_W'(i), 10'h000}) begin
                n_fail++; $display("FAIL clear_word%0d: wren=%b busy=%b addr=%0h data=%0h want 1 1 %0h 0",
                                   i, ram_wren, busy, ram_wraddress, ram_data, i);
            end
            if (i == 0) pb_store = 1'b1;
            if (i == 1) pb_store = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({ram_wren, busy, seq_len, full, overflow, edit_pattern} !== '0) begin
            n_fail++; $display("FAIL clear_done: wren=%b busy=%b len=%0d full=%b ovf=%b edit=%0h, all must be 0",
                               ram_wren, busy, seq_len, full, overflow, edit_pattern);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ram_wren, seq_len} !== '0) begin
            n_fail++; $display("FAIL store_in_clear: wren=%b len=%0d want 0 0", ram_wren, seq_len);
        end
    endtask

    task automatic test_full;
        press(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            press(0, 0, 1, 0);
            @(negedge clk);
            n_checks++;
            if ({ram_wren, ram_wraddress, ram_data} !== {1'b1, ADDR_W'(i), 10'h008}) begin
                n_fail++; $display("FAIL fill_write%0d: wren=%b addr=%0h data=%0h want 1 %0h 008",
                                   i, ram_wren, ram_wraddress, ram_data, i);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({seq_len, full, overflow} !== {11'd4, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL filled: len=%0d full=%b ovf=%b want 4 1 0", seq_len, full, overflow);
        end
        press(0, 0, 1, 0);
        @(negedge clk);
`ifdef REC_OVERWRITE_EN
        n_checks++;
        if ({ram_wren, ram_wraddress, overflow} !== {1'b1, 10'd0, 1'b0}) begin
            n_fail++; $display("FAIL wrap_write: wren=%b addr=%0h ovf=%b want 1 0 0", ram_wren, ram_wraddress, overflow);
        end
        @(negedge clk);
        n_checks++;
        if ({seq_len, full, overflow} !== {11'd4, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL wrap_after: len=%0d full=%b ovf=%b want 4 1 0", seq_len, full, overflow);
        end
`else
        n_checks++;
        if ({ram_wren, overflow} !== {1'b0, 1'b1}) begin
            n_fail++; $display("FAIL drop_store: wren=%b ovf=%b want 0 1", ram_wren, overflow);
        end
        @(negedge clk);
        n_checks++;
        if ({ram_wren, seq_len, full, overflow} !== {1'b0, 11'd4, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL drop_after: wren=%b len=%0d full=%b ovf=%b want 0 4 1 1",
                               ram_wren, seq_len, full, overflow);
        end
`endif
    endtask

    task automatic test_reset_mid_clear;
        press(0, 0, 0, 1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (ram_wren !== 1'b1) begin
            n_fail++; $display("FAIL mid_clear_active: wren=%b want 1", ram_wren);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ram_wraddress, ram_data, ram_wren, edit_pattern, cursor, seq_len, busy, full, overflow} !== '0) begin
            n_fail++; $display("FAIL async_reset_outputs: wren=%b addr=%0h busy=%b len=%0d cur=%0d edit=%0h, all must be 0",
                               ram_wren, ram_wraddress, busy, seq_len, cursor, edit_pattern);
        end
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL async_reset_state: got %0d want IDLE", dut.r_state);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.r_state !== EDIT) begin
            n_fail++; $display("FAIL reenter_edit: got %0d want EDIT", dut.r_state);
        end
    endtask

    initial begin
        test_reset();
        test_edit_store();
        test_same_cycle();
        test_clear();
        test_full();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
